imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Parametrised, registered immediate-extension stage for the decode/execute boundary. It replaces the purely combinational extender. Additions over the old block:
- Generic immediate and datapath widths.
- A branch-offset mode.
- A two-instruction HI/LO constant-merge mode that builds a full-width constant across two accepted inputs.
- valid/ready handshaking on both sides, so the stage can stall with the pipeline.

## Interface
- IMM_W, default 16: immediate field width.
- DATA_W, default 32: extended output width; must be ≥ 2*IMM_W.
- OP_LEN, default 3: opcode width, equal to the shared IEXT_OP_LEN.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- flush  in  1  pipeline flush: drops the held output and any pending HI half.
- in_valid  in  1  input transfer request.
- in_ready  out  1  stage can accept input this cycle.
- in_imm  in  IMM_W  raw immediate field.
- in_op  in  OP_LEN  extension opcode.
- out_valid  out  1  out_data/out_err hold a result.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  DATA_W  extended value.
- out_err  out  1  result came from an illegal opcode or an orphan LO_MERGE.

## Operation
- Opcodes (package constants):
  - ZERO_EXT=0: {0, imm}.
  - SIGNED_EXT=1: sign-extend imm[IMM_W-1].
  - SHIFTL=2: {imm, 0}, zero-filled, truncated/extended to DATA_W.
  - BR_OFS=3: sign-extend, then shift left by 2; bits shifted out beyond DATA_W are discarded.
  - HI_LOAD=4: hi_reg ← imm, hi_valid ← 1; produces no output.
  - LO_MERGE=5: {hi_reg, imm} zero-extended to DATA_W; clears hi_valid.
  - Codes 6–7 and any other undefined code: out_data=0, out_err=1.
- LO_MERGE with hi_valid=0: out_data={0, imm}, out_err=1.
- A second HI_LOAD overwrites hi_reg; hi_valid stays 1.
- Transfer: in_valid && in_ready at a rising edge.
- in_ready = !flush && (!out_valid || out_ready), which gives full throughput with no bubble.
- An accepted non-HI_LOAD op loads the output register: out_valid ← 1.
- An accepted HI_LOAD sets out_valid ← 0 if the old result drained in the same cycle, otherwise out_valid holds.
- Stall (out_valid && !out_ready): out_data, out_err and out_valid hold stable. in_ready=0.
- flush: out_valid ← 0 and hi_valid ← 0. No input is accepted that cycle. flush takes priority over everything except rst.
- Output register state for an illegal-opcode result: out_err=1, out_data=0.

## Timing
- Latency: input accepted at edge N → result visible with out_valid=1 after edge N, held until it is consumed at a later edge.
- Throughput: one result per cycle when out_ready=1 continuously.
- Reset values: out_valid=0, out_data=0, out_err=0, hi_valid=0, hi_reg=0.
- During a reset cycle, in_ready=0.
- Reset asserted mid-operation discards the held result and the pending HI half at the next edge.
- Simultaneous out_ready and accept: old result leaves and new result loads at the same edge.
- Simultaneous HI_LOAD accept and LO_MERGE: impossible, because there is a single input port.
- Back-to-back HI_LOAD, LO_MERGE: LO_MERGE sees the hi_reg written at the previous edge.

## Structure
- Package alicepu_iext_pkg holds:
  - IEXT_OP_LEN.
  - The eight opcode constants.
  - The op typedef.
- Sub-module imm_ext_core: combinational function of (imm, op, hi_reg, hi_valid) → (data, err, is_hi_load). It is parametrised by IMM_W and DATA_W.
- imm_ext_pipe owns hi_reg/hi_valid, the output register and the handshake logic.
- Elaboration-time check: DATA_W ≥ 2*IMM_W.

## Test plan
- Reset, then the default parameters, out_ready=1:
  - ZERO_EXT 0x8001 → 0x00008001.
  - SIGNED_EXT 0x8001 → 0xFFFF8001.
  - SHIFTL 0x1234 → 0x12340000.
  - BR_OFS 0xFFFF → 0xFFFFFFFC.
  - All with out_err=0, one per cycle.
- HI_LOAD 0xDEAD then LO_MERGE 0xBEEF → single result 0xDEADBEEF. No output is produced for HI_LOAD.
- LO_MERGE 0x0042 after reset → out_data=0x00000042, out_err=1.
- Opcode 7, imm 0xFFFF → out_data=0, out_err=1.
- Stall test:
  - Hold out_ready=0 for 3 cycles with a result pending → out_data stable, in_ready=0.
  - Release → next queued input appears on the following edge.
- HI_LOAD 0x1111, flush, LO_MERGE 0x2222 → out_data=0x00002222, out_err=1. A result held during the flush is dropped.
- IMM_W=8, DATA_W=24:
  - HI_LOAD 0xAB, LO_MERGE 0xCD → 0x00ABCD.
  - SIGNED_EXT 0x80 → 0xFFFF80.

Source files
------------

// File: rtl/alicepu_iext_pkg.sv
// Shared opcode encoding for the immediate-extension stage.
package alicepu_iext_pkg;

  localparam int IEXT_OP_LEN = 3;

  typedef enum logic [IEXT_OP_LEN-1:0] {
    IEXT_ZERO_EXT   = 3'd0,
    IEXT_SIGNED_EXT = 3'd1,
    IEXT_SHIFTL     = 3'd2,
    IEXT_BR_OFS     = 3'd3,
    IEXT_HI_LOAD    = 3'd4,
    IEXT_LO_MERGE   = 3'd5,
    IEXT_RSV6       = 3'd6,
    IEXT_RSV7       = 3'd7
  } iext_op_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: one result per opcode, plus the HI half
// bookkeeping flag consumed by the surrounding pipeline stage.
module imm_ext_core
  import alicepu_iext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OP_LEN = IEXT_OP_LEN
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [OP_LEN-1:0] op_i,
  input  logic [IMM_W-1:0]  hi_reg_i,
  input  logic              hi_valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              is_hi_load_o
);

  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] merged;

  assign zext   = DATA_W'(imm_i);
  assign sext   = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign merged = DATA_W'({hi_reg_i, imm_i});

  always_comb begin
    data_o       = '0;
    err_o        = 1'b0;
    is_hi_load_o = 1'b0;
    case (op_i)
      IEXT_ZERO_EXT:   data_o = zext;
      IEXT_SIGNED_EXT: data_o = sext;
      IEXT_SHIFTL:     data_o = zext << IMM_W;
      IEXT_BR_OFS:     data_o = sext << 2;
      IEXT_HI_LOAD:    is_hi_load_o = 1'b1;
      IEXT_LO_MERGE: begin
        // An orphan LO half still forwards its bits, flagged as an error.
        data_o = hi_valid_i ? merged : zext;
        err_o  = !hi_valid_i;
      end
      default:         err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with valid/ready on both sides and a
// two-instruction HI/LO constant merge.
module imm_ext_pipe
  import alicepu_iext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OP_LEN = IEXT_OP_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [OP_LEN-1:0] in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  if (DATA_W < 2*IMM_W) begin : g_bad_width
    $error("imm_ext_pipe: DATA_W must be at least 2*IMM_W");
  end
  if (OP_LEN != IEXT_OP_LEN) begin : g_bad_oplen
    $error("imm_ext_pipe: OP_LEN must equal IEXT_OP_LEN");
  end

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_err_q,   out_err_d;
  logic [IMM_W-1:0]  hi_reg_q,    hi_reg_d;
  logic              hi_valid_q,  hi_valid_d;

  logic [DATA_W-1:0] core_data;
  logic              core_err;
  logic              core_hi_load;
  logic              accept;

  imm_ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W),
    .OP_LEN (OP_LEN)
  ) u_core (
    .imm_i        (in_imm),
    .op_i         (in_op),
    .hi_reg_i     (hi_reg_q),
    .hi_valid_i   (hi_valid_q),
    .data_o       (core_data),
    .err_o        (core_err),
    .is_hi_load_o (core_hi_load)
  );

  // Ready looks through a draining result so a full stage still streams.
  assign in_ready = !rst && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    hi_reg_d    = hi_reg_q;
    hi_valid_d  = hi_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
      hi_valid_d  = 1'b0;
    end else if (accept) begin
      if (core_hi_load) begin
        // Acceptance implies any old result drained, so nothing is left held.
        hi_reg_d    = in_imm;
        hi_valid_d  = 1'b1;
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = core_data;
        out_err_d   = core_err;
        if (in_op == IEXT_LO_MERGE) hi_valid_d = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      hi_reg_q    <= '0;
      hi_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      hi_reg_q    <= hi_reg_d;
      hi_valid_q  <= hi_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: directed literal checks plus randomized traffic on a
// default instance and a narrow (8/24) instance against an arithmetic model.
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_fl = 1'b0, a_iv = 1'b0, a_ordy = 1'b1;
  logic [15:0] a_imm = '0;
  logic [2:0]  a_op  = '0;
  logic        a_ir, a_ov, a_oe;
  logic [31:0] a_od;

  logic        b_rst = 1'b1, b_fl = 1'b0, b_iv = 1'b0, b_ordy = 1'b1;
  logic [7:0]  b_imm = '0;
  logic [2:0]  b_op  = '0;
  logic        b_ir, b_ov, b_oe;
  logic [23:0] b_od;

  imm_ext_pipe u_a (
    .clk(clk), .rst(a_rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_imm(a_imm), .in_op(a_op), .out_valid(a_ov), .out_ready(a_ordy),
    .out_data(a_od), .out_err(a_oe)
  );

  imm_ext_pipe #(.IMM_W(8), .DATA_W(24)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_imm(b_imm), .in_op(b_op), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .out_err(b_oe)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: values from plain arithmetic on the opcode rules.
  function automatic longint unsigned ext_m(int iw, int dw, longint unsigned imm,
                                            int op, longint unsigned hi, bit hv,
                                            output bit err);
    longint unsigned pw_i, pw_d, s;
    pw_i = 64'd1 << iw;
    pw_d = 64'd1 << dw;
    s    = (imm >= (pw_i >> 1)) ? imm + pw_d - pw_i : imm;
    err  = 1'b0;
    case (op)
      0: return imm;
      1: return s;
      2: return (imm * pw_i) % pw_d;
      3: return (s * 4) % pw_d;
      4: return 0;
      5: begin err = !hv; return hv ? hi * pw_i + imm : imm; end
      default: begin err = 1'b1; return 0; end
    endcase
  endfunction

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        e;
    logic [15:0] hi;
    logic        hv;
  } mst_t;

  function automatic mst_t step(int iw, int dw, mst_t s, bit r, bit fl, bit iv,
                                bit ordy, longint unsigned imm, int op);
    mst_t n;
    bit e;
    longint unsigned x;
    n = s;
    if (r) n = '0;
    else if (fl) begin
      n.v  = 1'b0;
      n.hv = 1'b0;
    end else if (iv && (!s.v || ordy)) begin
      x = ext_m(iw, dw, imm, op, 64'(s.hi), s.hv, e);
      if (op == 4) begin
        n.hi = imm[15:0];
        n.hv = 1'b1;
        n.v  = 1'b0;
      end else begin
        n.v = 1'b1;
        n.d = x[31:0];
        n.e = e;
        if (op == 5) n.hv = 1'b0;
      end
    end else if (ordy) n.v = 1'b0;
    return n;
  endfunction

  mst_t ma = '0, mb = '0;

  always @(posedge clk) begin
    ma <= step(16, 32, ma, a_rst, a_fl, a_iv, a_ordy, 64'(a_imm), int'(a_op));
    mb <= step(8, 24, mb, b_rst, b_fl, b_iv, b_ordy, 64'(b_imm), int'(b_op));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_in_ready", 64'(a_ir), 64'(!a_rst && !a_fl && (!ma.v || a_ordy)));
      chk("a_out_valid", 64'(a_ov), 64'(ma.v));
      if (ma.v) begin
        chk("a_out_data", 64'(a_od), 64'(ma.d));
        chk("a_out_err", 64'(a_oe), 64'(ma.e));
      end
      chk("b_in_ready", 64'(b_ir), 64'(!b_rst && !b_fl && (!mb.v || b_ordy)));
      chk("b_out_valid", 64'(b_ov), 64'(mb.v));
      if (mb.v) begin
        chk("b_out_data", 64'(b_od), 64'(mb.d[23:0]));
        chk("b_out_err", 64'(b_oe), 64'(mb.e));
      end
    end
  end

  // Drive after the edge; the state seen at the following negedge reflects
  // the inputs of the previous tick.
  task automatic tick_a(bit iv, int op, int imm, bit ordy, bit fl);
    @(posedge clk); #1;
    a_iv = iv; a_op = 3'(op); a_imm = 16'(imm); a_ordy = ordy; a_fl = fl;
    @(negedge clk);
  endtask

  task automatic tick_b(bit iv, int op, int imm);
    @(posedge clk); #1;
    b_iv = iv; b_op = 3'(op); b_imm = 8'(imm); b_ordy = 1'b1; b_fl = 1'b0;
    @(negedge clk);
  endtask

  task automatic exp_a(string name, bit v, longint unsigned d, bit e);
    chk({name, "_valid"}, 64'(a_ov), 64'(v));
    if (v) begin
      chk({name, "_data"}, 64'(a_od), d);
      chk({name, "_err"}, 64'(a_oe), 64'(e));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    a_rst = 1'b1; b_rst = 1'b1; a_iv = 1'b0; b_iv = 1'b0; a_fl = 1'b0; b_fl = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_a", 64'(a_ir), 0);
    chk("rst_in_ready_b", 64'(b_ir), 0);
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_a", 64'(a_ov), 0);
    chk("rst_data_a", 64'(a_od), 0);
    chk("rst_err_a", 64'(a_oe), 0);
    chk("rst_valid_b", 64'(b_ov), 0);
    chk("rst_data_b", 64'(b_od), 0);
  endtask

  initial begin
    int r;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset();

    // One result per cycle across the four extension modes.
    tick_a(1, 0, 'h8001, 1, 0);
    tick_a(1, 1, 'h8001, 1, 0);
    exp_a("zext", 1, 'h00008001, 0);
    tick_a(1, 2, 'h1234, 1, 0);
    exp_a("sext", 1, 'hFFFF8001, 0);
    tick_a(1, 3, 'hFFFF, 1, 0);
    exp_a("shiftl", 1, 'h12340000, 0);
    tick_a(0, 0, 0, 1, 0);
    exp_a("br_ofs", 1, 'hFFFFFFFC, 0);
    tick_a(0, 0, 0, 1, 0);
    exp_a("drain", 0, 0, 0);

    // HI/LO merge: the HI half yields no output.
    tick_a(1, 4, 'hDEAD, 1, 0);
    tick_a(1, 5, 'hBEEF, 1, 0);
    exp_a("hi_no_out", 0, 0, 0);
    tick_a(0, 0, 0, 1, 0);
    exp_a("merge", 1, 'hDEADBEEF, 0);
    tick_a(0, 0, 0, 1, 0);
    exp_a("merge_single", 0, 0, 0);

    do_reset();
    tick_a(1, 5, 'h0042, 1, 0);
    tick_a(0, 0, 0, 1, 0);
    exp_a("orphan_lo", 1, 'h00000042, 1);

    tick_a(1, 7, 'hFFFF, 1, 0);
    tick_a(0, 0, 0, 1, 0);
    exp_a("illegal_op", 1, 0, 1);

    // Stall: three cycles with out_ready low, then release.
    tick_a(1, 0, 'h5555, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick_a(1, 0, 'h6666, 0, 0);
      exp_a("stall_hold", 1, 'h5555, 0);
      chk("stall_in_ready", 64'(a_ir), 0);
    end
    tick_a(1, 0, 'h6666, 1, 0);
    chk("release_in_ready", 64'(a_ir), 1);
    exp_a("release_old", 1, 'h5555, 0);
    tick_a(0, 0, 0, 1, 0);
    exp_a("release_new", 1, 'h6666, 0);
    tick_a(0, 0, 0, 1, 0);

    // Flush drops both the held result and the pending HI half.
    tick_a(1, 4, 'h1111, 1, 0);
    tick_a(1, 0, 'h7777, 0, 0);
    tick_a(0, 0, 0, 0, 1);
    exp_a("pre_flush", 1, 'h7777, 0);
    chk("flush_in_ready", 64'(a_ir), 0);
    tick_a(1, 5, 'h2222, 1, 0);
    exp_a("flushed", 0, 0, 0);
    tick_a(0, 0, 0, 1, 0);
    exp_a("flush_orphan", 1, 'h00002222, 1);

    // Narrow instance.
    tick_b(1, 4, 'hAB);
    tick_b(1, 5, 'hCD);
    chk("b_hi_no_out", 64'(b_ov), 0);
    tick_b(1, 1, 'h80);
    chk("b_merge_valid", 64'(b_ov), 1);
    chk("b_merge_data", 64'(b_od), 'h00ABCD);
    chk("b_merge_err", 64'(b_oe), 0);
    tick_b(0, 0, 0);
    chk("b_sext_data", 64'(b_od), 'hFFFF80);
    chk("b_sext_err", 64'(b_oe), 0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 11);
      a_op   = 3'((r < 8) ? r : ((r < 10) ? 4 : 5));
      a_imm  = 16'($urandom);
      a_iv   = ($urandom_range(0, 3) != 0);
      a_ordy = ($urandom_range(0, 9) < 7);
      a_fl   = ($urandom_range(0, 39) == 0);
      a_rst  = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 11);
      b_op   = 3'((r < 8) ? r : ((r < 10) ? 4 : 5));
      b_imm  = 8'($urandom);
      b_iv   = ($urandom_range(0, 3) != 0);
      b_ordy = ($urandom_range(0, 9) < 7);
      b_fl   = ($urandom_range(0, 39) == 0);
      b_rst  = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    a_iv = 1'b0; b_iv = 1'b0; a_rst = 1'b0; b_rst = 1'b0;
    a_fl = 1'b0; b_fl = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
